// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding request to the memory controller, 2-entry instr/pc buffer toward decode.
// Latency: request registered on the edge a buffer slot is free; its word is written MC_LAT edges later.
// Backpressure: no request unless a slot is free at write time; if_id_valid comes only from the registered count.
module instr_fetch #(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MC_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [31:0]       mc_if_data,
  input  logic              redir_en,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              if_id_valid,
  input  logic              if_id_ready,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  localparam logic [2:0] LAT = 3'(MC_LAT);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       buf_instr [2];
  logic [ADDR_W-1:0] buf_pc    [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              issue, push, pop, last_beat;

  // A pop is lost to a redirect, since the buffer is being cleared anyway.
  assign pop       = if_id_valid && if_id_ready && !redir_en;
  assign last_beat = (cnt == 3'd1);

  assign if_id_valid = (count != 2'd0);
  assign if_id_instr = buf_instr[rd_ptr];
  assign if_id_pc    = buf_pc[rd_ptr];

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: issue when a slot is guaranteed, count down the outstanding request, drop it after a redirect.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!redir_en && (count < 2'd2 || pop)) begin
          issue     = 1'b1;
          cnt_nxt   = LAT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (last_beat) begin
          // Data arrives this edge; a redirect in the same cycle discards it.
          push      = !redir_en;
          state_nxt = IDLE;
        end else if (redir_en) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        cnt_nxt = cnt - 3'd1;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch PC and registered request outputs; if_mc_addr doubles as the outstanding request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      if_mc_en   <= 1'b0;
      if_mc_addr <= '0;
    end else begin
      if_mc_en <= issue;
      if (issue) if_mc_addr <= pc;
      if (redir_en)  pc <= redir_pc & ~ADDR_W'(3);
      else if (push) pc <= pc + ADDR_W'(4);
    end
  end

  // Two-entry buffer of {instr, pc}; a redirect empties it and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redir_en) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= mc_if_data;
        buf_pc[wr_ptr]    <= if_mc_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
